// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared Y86 encodings (icodes, status codes, RNONE), FSM state type and
// classification helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd2;
    localparam logic [2:0] S_INS = 3'd3;
    localparam logic [2:0] S_HLT = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Instructions whose M stage touches data memory.
    function automatic logic is_memop(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_RMMOVQ) || (icode == I_PUSHQ) ||
               (icode == I_POPQ)   || (icode == I_CALL)   || (icode == I_RET);
    endfunction

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble control for the 5-stage Y86 pipeline, with data-memory wait
// handling, wait timeout, sticky halt and saturating hazard counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int ICODE_W = 4,
    parameter int STAT_W  = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ICODE_W-1:0] D_icode_i,
    input  logic [REG_W-1:0]   d_srcA_i,
    input  logic [REG_W-1:0]   d_srcB_i,
    input  logic [ICODE_W-1:0] E_icode_i,
    input  logic [REG_W-1:0]   E_dstM_i,
    input  logic               e_Cnd_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [STAT_W-1:0]  m_stat_i,
    input  logic [STAT_W-1:0]  W_stat_i,
    input  logic               dmem_ready_i,
    output logic               F_stall_o,
    output logic               D_stall_o,
    output logic               M_stall_o,
    output logic               W_stall_o,
    output logic               D_bubble_o,
    output logic               E_bubble_o,
    output logic               M_bubble_o,
    output logic               W_bubble_o,
    output logic               set_cc_o,
    output logic               halted_o,
    output logic               mem_timeout_o,
    output logic [CNT_W-1:0]   lu_cnt_o,
    output logic [CNT_W-1:0]   ret_cnt_o,
    output logic [CNT_W-1:0]   mp_cnt_o
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    logic lu, ret, mp, exc_m, exc_w, memop, mw;

    assign lu = ((E_icode_i == ICODE_W'(I_MRMOVQ)) || (E_icode_i == ICODE_W'(I_POPQ))) &&
                (E_dstM_i != REG_W'(RNONE)) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

    assign ret = (D_icode_i == ICODE_W'(I_RET)) ||
                 (E_icode_i == ICODE_W'(I_RET)) ||
                 (M_icode_i == ICODE_W'(I_RET));

    assign mp    = (E_icode_i == ICODE_W'(I_JXX)) && !e_Cnd_i;
    assign exc_m = is_exc(3'(m_stat_i));
    assign exc_w = is_exc(3'(W_stat_i));
    assign memop = is_memop(4'(M_icode_i));
    assign mw    = memop && !dmem_ready_i;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_to, mem_to_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_to   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_MWAIT) ? wait_cnt + 1'b1 : '0;
            mem_to   <= mem_to_nxt;
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        mem_to_nxt = mem_to;
        case (state)
            ST_RUN: begin
                if (exc_w) begin
                    state_nxt = ST_HALT;
                end else if (mw) begin
                    state_nxt = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (exc_w) begin
                    state_nxt = ST_HALT;
                end else if (dmem_ready_i) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive not-ready cycle in MWAIT.
                    state_nxt  = ST_HALT;
                    mem_to_nxt = 1'b1;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        F_stall_o     = 1'b0;
        D_stall_o     = 1'b0;
        M_stall_o     = 1'b0;
        W_stall_o     = 1'b0;
        D_bubble_o    = 1'b0;
        E_bubble_o    = 1'b0;
        M_bubble_o    = 1'b0;
        W_bubble_o    = 1'b0;
        set_cc_o      = 1'b0;
        halted_o      = 1'b0;
        mem_timeout_o = 1'b0;
        if (rst_i) begin
            F_stall_o  = 1'b1;
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (state == ST_HALT) begin
            F_stall_o     = 1'b1;
            D_stall_o     = 1'b1;
            M_stall_o     = 1'b1;
            W_stall_o     = 1'b1;
            D_bubble_o    = 1'b1;
            E_bubble_o    = 1'b1;
            M_bubble_o    = 1'b1;
            halted_o      = 1'b1;
            mem_timeout_o = mem_to;
        end else begin
            // A memory wait freezes the hazard pipeline and overrides hazard bubbles.
            F_stall_o  = lu || ret || mw;
            D_stall_o  = lu || mw;
            D_bubble_o = !mw && (mp || (ret && !lu));
            E_bubble_o = !mw && (mp || lu);
            M_stall_o  = mw;
            W_bubble_o = mw && !exc_w;
            M_bubble_o = !mw && (exc_m || exc_w);
            W_stall_o  = exc_w;
            set_cc_o   = (E_icode_i == ICODE_W'(I_OPQ)) && !mw && !exc_m && !exc_w;
        end
    end

    logic count_en;
    assign count_en = !rst_i && (state != ST_HALT);

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (count_en && lu && !mw),
        .cnt_o (lu_cnt_o)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (count_en && ret && !lu && !mw),
        .cnt_o (ret_cnt_o)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (count_en && mp && !mw),
        .cnt_o (mp_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules, wait timeout, halt and counters.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0] d_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [2:0] m_stat;
        logic [2:0] w_stat;
        logic       ready;
        logic       rst;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       d_icode, d_srca, d_srcb, e_icode, e_dstm, m_icode;
    logic             e_cnd, dmem_ready;
    logic [2:0]       m_stat, w_stat;
    logic             f_stall, d_stall, m_stall, w_stall;
    logic             d_bubble, e_bubble, m_bubble, w_bubble;
    logic             set_cc, halted, mem_timeout;
    logic [CNT_W-1:0] lu_cnt, ret_cnt, mp_cnt;

    pipe_hazard_ctrl #(
        .REG_W(4), .ICODE_W(4), .STAT_W(3), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(d_icode), .d_srcA_i(d_srca), .d_srcB_i(d_srcb),
        .E_icode_i(e_icode), .E_dstM_i(e_dstm), .e_Cnd_i(e_cnd),
        .M_icode_i(m_icode), .m_stat_i(m_stat), .W_stat_i(w_stat),
        .dmem_ready_i(dmem_ready),
        .F_stall_o(f_stall), .D_stall_o(d_stall), .M_stall_o(m_stall), .W_stall_o(w_stall),
        .D_bubble_o(d_bubble), .E_bubble_o(e_bubble), .M_bubble_o(m_bubble), .W_bubble_o(w_bubble),
        .set_cc_o(set_cc), .halted_o(halted), .mem_timeout_o(mem_timeout),
        .lu_cnt_o(lu_cnt), .ret_cnt_o(ret_cnt), .mp_cnt_o(mp_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model state: halted flag, timeout flag, waiting flag, cycles spent waiting, counters.
    bit m_halt, m_to, m_wait;
    int m_waited, m_lu, m_ret, m_mp;

    function automatic stim_t idle();
        stim_t s;
        s.d_icode = I_NOP;  s.srca = RNONE; s.srcb = RNONE;
        s.e_icode = I_NOP;  s.e_dstm = RNONE; s.cnd = 1'b1;
        s.m_icode = I_NOP;  s.m_stat = S_AOK; s.w_stat = S_AOK;
        s.ready = 1'b1;     s.rst = 1'b0;
        return s;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input string tag, input stim_t s);
        bit lu, ret, mp, excm, excw, memop, mw;
        logic [10:0] exp_v, obs_v;
        rst = s.rst; d_icode = s.d_icode; d_srca = s.srca; d_srcb = s.srcb;
        e_icode = s.e_icode; e_dstm = s.e_dstm; e_cnd = s.cnd; m_icode = s.m_icode;
        m_stat = s.m_stat; w_stat = s.w_stat; dmem_ready = s.ready;
        #1;
        lu    = (s.e_icode == I_MRMOVQ || s.e_icode == I_POPQ) && s.e_dstm != RNONE &&
                (s.e_dstm == s.srca || s.e_dstm == s.srcb);
        ret   = s.d_icode == I_RET || s.e_icode == I_RET || s.m_icode == I_RET;
        mp    = s.e_icode == I_JXX && !s.cnd;
        excm  = s.m_stat inside {S_ADR, S_INS, S_HLT};
        excw  = s.w_stat inside {S_ADR, S_INS, S_HLT};
        memop = s.m_icode inside {I_MRMOVQ, I_RMMOVQ, I_PUSHQ, I_POPQ, I_CALL, I_RET};
        mw    = memop && !s.ready;
        // order: F D M W stall, D E M W bubble, set_cc, halted, mem_timeout
        if (s.rst)
            exp_v = 11'b1000_1110_000;
        else if (m_halt)
            exp_v = {4'b1111, 4'b1110, 1'b0, 1'b1, m_to};
        else
            exp_v = {lu | ret | mw, lu | mw, mw, excw,
                     !mw & (mp | (ret & !lu)), !mw & (mp | lu), !mw & (excm | excw), mw & !excw,
                     s.e_icode == I_OPQ && !mw && !excm && !excw, 1'b0, 1'b0};
        obs_v = {f_stall, d_stall, m_stall, w_stall, d_bubble, e_bubble, m_bubble, w_bubble,
                 set_cc, halted, mem_timeout};
        check({tag, "_ctrl"}, 64'(obs_v), 64'(exp_v));
        if (!s.rst) begin
            check({tag, "_lu_cnt"},  64'(lu_cnt),  64'(m_lu));
            check({tag, "_ret_cnt"}, 64'(ret_cnt), 64'(m_ret));
            check({tag, "_mp_cnt"},  64'(mp_cnt),  64'(m_mp));
        end
        if (s.rst) begin
            m_halt = 0; m_to = 0; m_wait = 0; m_waited = 0; m_lu = 0; m_ret = 0; m_mp = 0;
        end else if (!m_halt) begin
            if (lu && !mw)        m_lu  = sat_inc(m_lu);
            if (ret && !lu && !mw) m_ret = sat_inc(m_ret);
            if (mp && !mw)        m_mp  = sat_inc(m_mp);
            if (excw) begin
                m_halt = 1;
            end else if (m_wait) begin
                m_waited++;
                if (s.ready) m_wait = 0;
                else if (m_waited == TIMEOUT) begin m_halt = 1; m_to = 1; end
            end else if (mw) begin
                m_wait = 1; m_waited = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(); s.rst = 1'b1;
        step("reset", s);
        step("reset", s);
    endtask

    initial begin
        stim_t s;
        int halt_run;
        @(negedge clk);
        do_reset();

        // Load-use hazard, then RNONE must not match.
        s = idle(); s.e_icode = I_MRMOVQ; s.e_dstm = 4'd3; s.srca = 4'd3;
        step("t1_lu", s);
        check("t1_lu_cnt_after", 64'(lu_cnt), 64'd1);
        s = idle(); s.e_icode = I_MRMOVQ; s.e_dstm = RNONE; s.srca = RNONE;
        step("t2_rnone", s);
        do_reset();
        s = idle(); s.d_icode = I_RET;
        repeat (3) step("t2_ret", s);
        check("t2_ret_cnt_after", 64'(ret_cnt), 64'd3);

        // Mispredict, then exception in M suppresses set_cc.
        s = idle(); s.e_icode = I_JXX; s.cnd = 1'b0;
        step("t3_mp", s);
        check("t3_mp_cnt_after", 64'(mp_cnt), 64'd1);
        s = idle(); s.e_icode = I_OPQ; s.m_stat = S_ADR;
        step("t3_exc_m", s);

        // Short memory wait resolved before the timeout.
        s = idle(); s.m_icode = I_MRMOVQ; s.ready = 1'b0;
        repeat (3) step("t4_wait", s);
        s.ready = 1'b1;
        step("t4_done", s);
        step("t4_run", idle());
        check("t4_not_halted", 64'(halted), 64'd0);

        // Memory never ready: halt with timeout on the 5th edge, sticky.
        do_reset();
        s = idle(); s.m_icode = I_MRMOVQ; s.ready = 1'b0;
        repeat (4) step("t5_wait", s);
        check("t5_halt_before_timeout", 64'(halted), 64'd0);
        step("t5_wait", s);
        check("t5_halted", 64'(halted), 64'd1);
        check("t5_timeout", 64'(mem_timeout), 64'd1);
        repeat (3) step("t5_sticky", idle());
        check("t5_still_halted", 64'(halted), 64'd1);
        do_reset();
        check("t5_lu_cnt_reset", 64'(lu_cnt), 64'd0);
        check("t5_timeout_reset", 64'(mem_timeout), 64'd0);

        // Halt from write-back status; then counter saturation.
        s = idle(); s.w_stat = S_HLT;
        step("t6_shlt", s);
        repeat (3) step("t6_sticky", idle());
        check("t6_halted", 64'(halted), 64'd1);
        check("t6_no_timeout", 64'(mem_timeout), 64'd0);
        do_reset();
        s = idle(); s.e_icode = I_MRMOVQ; s.e_dstm = 4'd3; s.srca = 4'd3;
        repeat (MAXC - 1) step("t6_lu", s);
        check("t6_lu_near_max", 64'(lu_cnt), 64'(MAXC - 1));
        repeat (3) step("t6_lu_sat", s);
        check("t6_lu_saturated", 64'(lu_cnt), 64'(MAXC));

        // Randomized traffic with occasional resets.
        do_reset();
        halt_run = 0;
        for (int i = 0; i < 3000; i++) begin
            s.d_icode = 4'($urandom_range(0, 11));
            s.srca    = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 4));
            s.srcb    = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 4));
            s.e_icode = 4'($urandom_range(0, 11));
            s.e_dstm  = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 4));
            s.cnd     = 1'($urandom_range(0, 1));
            s.m_icode = 4'($urandom_range(0, 11));
            s.m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : S_AOK;
            s.w_stat  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(2, 4)) : S_AOK;
            s.ready   = ($urandom_range(0, 3) != 0);
            s.rst     = ($urandom_range(0, 99) == 0) || (halt_run > 6);
            halt_run  = m_halt ? halt_run + 1 : 0;
            step("rand", s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
